resq_dispatch_controller: RTL and testbench

//  Consumer end of the ResQ queue interface. Watches the merged head-of-queue

---
 rtl/resq_pkg.sv | 18 +
 rtl/team_allocator.sv | 23 ++
 rtl/resq_dispatch_controller.sv | 155 +++++++++++++++
 tb/tb_resq_dispatch_controller.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/resq_pkg.sv
// Shared types and constants for the ResQ dispatch controller.
package resq_pkg;

  localparam int unsigned DefZoneW = 8;
  localparam int unsigned PrioW    = 2;

  typedef enum logic [1:0] {
    StIdle,
    StServe,
    StOffer
  } state_e;

  // Index width that stays at least one bit wide, even when there is a single team.
  function automatic int unsigned clog2w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/team_allocator.sv
// Picks the lowest-index available team and reports whether any team is available.
module team_allocator
  import resq_pkg::*;
#(
  parameter int unsigned NTeams = 4,
  localparam int unsigned TeamW = clog2w(NTeams)
) (
  input  logic [NTeams-1:0] avail_i,
  output logic [TeamW-1:0]  idx_o,
  output logic              any_o
);

  // Scan from the top down so that the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = int'(NTeams) - 1; i >= 0; i--) begin
      if (avail_i[i]) idx_o = TeamW'(i);
    end
  end

  assign any_o = |avail_i;

endmodule

// File: rtl/resq_dispatch_controller.sv
// Pops the merged queue head, offers it to free field teams with timeout-driven
// retry, and tracks team occupancy and the number of accepted dispatches.
module resq_dispatch_controller
  import resq_pkg::*;
#(
  parameter int unsigned NTeams     = 4,
  parameter int unsigned AckTimeout = 16,
  parameter int unsigned ZoneW      = DefZoneW,
  localparam int unsigned TeamW     = clog2w(NTeams),
  localparam int unsigned TimerW    = clog2w(AckTimeout)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              head_valid_i,
  input  logic [ZoneW-1:0]  head_zone_i,
  input  logic [PrioW-1:0]  head_priority_i,
  input  logic              head_evac_i,
  output logic              serve_o,
  output logic              dispatch_valid_o,
  output logic [TeamW-1:0]  dispatch_team_o,
  output logic [ZoneW-1:0]  dispatch_zone_o,
  output logic [PrioW-1:0]  dispatch_priority_o,
  output logic              dispatch_evac_o,
  input  logic              dispatch_ack_i,
  input  logic [NTeams-1:0] team_done_i,
  output logic [NTeams-1:0] team_busy_o,
  output logic              dispatch_error_o,
  output logic [15:0]       dispatched_count_o
);

  state_e              state_q, state_d;
  logic [TeamW-1:0]    team_q, team_d;
  logic [ZoneW-1:0]    zone_q, zone_d;
  logic [PrioW-1:0]    prio_q, prio_d;
  logic                evac_q, evac_d;
  logic [NTeams-1:0]   tried_q, tried_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [NTeams-1:0]   busy_q, busy_d;
  logic [15:0]         count_q, count_d;

  logic [NTeams-1:0]   team_oh;
  logic [NTeams-1:0]   tried_next;
  logic [NTeams-1:0]   alloc_avail;
  logic [TeamW-1:0]    alloc_idx;
  logic                alloc_any;
  logic                timeout;
  logic [NTeams-1:0]   busy_set;
  logic                error;

  // One-hot of the team currently being offered.
  always_comb begin
    team_oh          = '0;
    team_oh[team_q]  = 1'b1;
  end

  // In OFFER the allocator looks for a retry candidate that excludes the team
  // that is timing out right now; in SERVE it only needs the free teams.
  assign tried_next  = tried_q | team_oh;
  assign alloc_avail = (state_q == StOffer) ? (~busy_q & ~tried_next) : ~busy_q;
  assign timeout     = (timer_q == TimerW'(AckTimeout - 1));

  team_allocator #(
    .NTeams (NTeams)
  ) u_team_allocator (
    .avail_i (alloc_avail),
    .idx_o   (alloc_idx),
    .any_o   (alloc_any)
  );

  // Next-state logic for the IDLE -> SERVE -> OFFER handshake.
  always_comb begin
    state_d  = state_q;
    team_d   = team_q;
    zone_d   = zone_q;
    prio_d   = prio_q;
    evac_d   = evac_q;
    tried_d  = tried_q;
    timer_d  = timer_q;
    count_d  = count_q;
    busy_set = '0;
    error    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (head_valid_i && !(&busy_q)) state_d = StServe;
      end
      StServe: begin
        zone_d  = head_zone_i;
        prio_d  = head_priority_i;
        evac_d  = head_evac_i;
        tried_d = '0;
        team_d  = alloc_idx;
        timer_d = '0;
        state_d = StOffer;
      end
      StOffer: begin
        if (dispatch_ack_i) begin
          busy_set = team_oh;
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          state_d = StIdle;
        end else if (timeout) begin
          tried_d = tried_next;
          if (alloc_any) begin
            team_d  = alloc_idx;
            timer_d = '0;
          end else begin
            error   = 1'b1;
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Done clears occupancy, an accepted offer sets it; both may land on one edge.
  assign busy_d = (busy_q & ~team_done_i) | busy_set;

  // State register; reset discards any captured request.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      team_q  <= '0;
      zone_q  <= '0;
      prio_q  <= '0;
      evac_q  <= 1'b0;
      tried_q <= '0;
      timer_q <= '0;
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      team_q  <= team_d;
      zone_q  <= zone_d;
      prio_q  <= prio_d;
      evac_q  <= evac_d;
      tried_q <= tried_d;
      timer_q <= timer_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign serve_o             = (state_q == StServe);
  assign dispatch_valid_o    = (state_q == StOffer);
  assign dispatch_team_o     = team_q;
  assign dispatch_zone_o     = zone_q;
  assign dispatch_priority_o = prio_q;
  assign dispatch_evac_o     = evac_q;
  assign team_busy_o         = busy_q;
  assign dispatch_error_o    = error;
  assign dispatched_count_o  = count_q;

endmodule

// File: tb/tb_resq_dispatch_controller.sv
// Scoreboard bench: the driver predicts every offer and error from the free-team
// set, a negedge monitor pops and compares whenever the DUT presents one.
module tb_resq_dispatch_controller;

  localparam int unsigned N  = 4;
  localparam int unsigned T  = 16;
  localparam int unsigned ZW = 8;
  localparam int unsigned TW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          head_valid;
  logic [ZW-1:0] head_zone;
  logic [1:0]    head_prio;
  logic          head_evac;
  logic          serve;
  logic          valid;
  logic [TW-1:0] team;
  logic [ZW-1:0] zone;
  logic [1:0]    prio;
  logic          evac;
  logic          ack;
  logic [N-1:0]  done;
  logic [N-1:0]  busy;
  logic          err;
  logic [15:0]   count;

  always #5 clk = ~clk;

  resq_dispatch_controller #(
    .NTeams     (N),
    .AckTimeout (T),
    .ZoneW      (ZW)
  ) dut (
    .clock_i             (clk),
    .reset_i             (rst),
    .head_valid_i        (head_valid),
    .head_zone_i         (head_zone),
    .head_priority_i     (head_prio),
    .head_evac_i         (head_evac),
    .serve_o             (serve),
    .dispatch_valid_o    (valid),
    .dispatch_team_o     (team),
    .dispatch_zone_o     (zone),
    .dispatch_priority_o (prio),
    .dispatch_evac_o     (evac),
    .dispatch_ack_i      (ack),
    .team_done_i         (done),
    .team_busy_o         (busy),
    .dispatch_error_o    (err),
    .dispatched_count_o  (count)
  );

  typedef struct {
    int          team;
    logic [7:0]  zone;
    logic [1:0]  prio;
    logic        evac;
  } offer_t;

  offer_t      exp_q[$];
  int          err_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [N-1:0] m_busy  = '0;
  int          m_count  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a new offer is valid rising or the offered team changing.
  logic          prev_valid = 1'b0;
  logic [TW-1:0] prev_team  = '0;
  always @(negedge clk) begin
    offer_t e;
    int     et;
    if (rst) begin
      prev_valid = 1'b0;
      prev_team  = '0;
    end else begin
      if (valid && (!prev_valid || team != prev_team)) begin
        if (exp_q.size() == 0) begin
          check("offer_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("offer_team", 32'(team), 32'(e.team));
          check("offer_zone", 32'(zone), 32'(e.zone));
          check("offer_prio", 32'(prio), 32'(e.prio));
          check("offer_evac", 32'(evac), 32'(e.evac));
        end
      end
      if (err) begin
        if (err_q.size() == 0) begin
          check("error_unexpected", 32'd1, 32'd0);
        end else begin
          et = err_q.pop_front();
          check("error_team", 32'(team), 32'(et));
        end
      end
      prev_valid = valid;
      prev_team  = team;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request: offers go to free teams in ascending order; the offer with
  // index k is acked d cycles into its window, or every free team times out
  // when k reaches the number of free teams.
  task automatic run_txn(input logic [7:0] z, input logic [1:0] p, input logic e, input int k_in,
                         input int d, input bit ack_in_serve, input bit serve_seen);
    int           free[$];
    int           nfree;
    int           k;
    int           last;
    bit           got;
    logic [N-1:0] dn;
    offer_t       o;
    for (int i = 0; i < int'(N); i++) if (!m_busy[i]) free.push_back(i);
    nfree = free.size();
    k     = (k_in > nfree) ? nfree : k_in;
    dn    = '0;
    for (int j = 0; j < nfree && j <= k; j++) begin
      o.team = free[j];
      o.zone = z;
      o.prio = p;
      o.evac = e;
      exp_q.push_back(o);
    end
    if (k == nfree) err_q.push_back(free[nfree-1]);
    head_zone  = z;
    head_prio  = p;
    head_evac  = e;
    head_valid = 1'b1;
    if (!serve_seen) begin
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        step();
        got = serve;
      end
      check("serve_seen", 32'(got), 32'd1);
      if (!got) begin
        head_valid = 1'b0;
        exp_q.delete();
        err_q.delete();
        return;
      end
    end
    // Ack during SERVE must be ignored.
    ack = ack_in_serve;
    step();
    ack        = 1'b0;
    head_valid = 1'b0;
    head_zone  = 8'($urandom);
    head_prio  = 2'($urandom);
    head_evac  = 1'($urandom);
    check("serve_to_valid", 32'(valid), 32'd1);
    check("serve_one_cycle", 32'(serve), 32'd0);
    last = (k == nfree) ? int'(T) * nfree - 1 : int'(T) * k + d;
    for (int c = 0; c <= last; c++) begin
      if (c > 0) step();
      if (k < nfree && c == last) begin
        ack  = 1'b1;
        dn   = N'($urandom);
        done = dn;
      end
      if (k == nfree && c == last) check("error_cycle", 32'(err), 32'd1);
    end
    step();
    ack  = 1'b0;
    done = '0;
    check("valid_drop", 32'(valid), 32'd0);
    if (k < nfree) begin
      m_busy = (m_busy & ~dn);
      m_busy[free[k]] = 1'b1;
      if (m_count < 65535) m_count++;
    end
    check("busy", 32'(busy), 32'(m_busy));
    check("count", 32'(count), 32'(m_count));
  endtask

  task automatic pulse_done(input logic [N-1:0] dn);
    done = dn;
    step();
    done   = '0;
    m_busy = m_busy & ~dn;
    step();
    check("busy_after_done", 32'(busy), 32'(m_busy));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    offer_t o;
    int     b;
    rst        = 1'b1;
    head_valid = 1'b1;
    head_zone  = 8'h2A;
    head_prio  = 2'b11;
    head_evac  = 1'b1;
    ack        = 1'b0;
    done       = '0;
    // Reset with a servable head held.
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_serve", 32'(serve), 32'd0);
    end
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_team", 32'(team), 32'd0);
    check("reset_zone", 32'(zone), 32'd0);
    check("reset_prio", 32'(prio), 32'd0);
    check("reset_evac", 32'(evac), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_error", 32'(err), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    rst = 1'b0;
    step();
    check("serve_after_reset", 32'(serve), 32'd1);

    // Basic: team 0 takes 2A/3/evac, acked 2 cycles after valid.
    run_txn(8'h2A, 2'b11, 1'b1, 0, 2, 1'b0, 1'b1);
    // Retry: team 0 times out, team 1 accepts.
    pulse_done(4'b0001);
    run_txn(8'($urandom), 2'($urandom), 1'($urandom), 1, 5, 1'b0, 1'b0);
    // Error: every free team times out.
    run_txn(8'($urandom), 2'($urandom), 1'($urandom), N, 0, 1'b1, 1'b0);

    // Randomized traffic, including the all-busy stall.
    for (int t = 0; t < 40; t++) begin
      if (&m_busy) begin
        head_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
          step();
          check("full_no_serve", 32'(serve), 32'd0);
        end
        b = $urandom_range(0, N - 1);
        done = '0;
        done[b] = 1'b1;
        step();
        done = '0;
        m_busy[b] = 1'b0;
      end
      run_txn(8'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, N),
              $urandom_range(0, T - 1), 1'($urandom), 1'b0);
      if ($urandom_range(0, 1) == 1) pulse_done(N'($urandom));
    end

    // Reset in the middle of an offer.
    if (&m_busy) pulse_done(4'b0001);
    for (int i = 0; i < int'(N); i++) begin
      if (!m_busy[i]) begin
        o.team = i;
        break;
      end
    end
    o.zone = 8'h5C;
    o.prio = 2'b01;
    o.evac = 1'b0;
    exp_q.push_back(o);
    head_zone  = o.zone;
    head_prio  = o.prio;
    head_evac  = o.evac;
    head_valid = 1'b1;
    b = 0;
    for (int w = 0; w < 20 && b == 0; w++) begin
      step();
      if (serve) b = 1;
    end
    check("serve_before_reset", 32'(b), 32'd1);
    step();
    head_valid = 1'b0;
    for (int c = 0; c < 5; c++) step();
    check("valid_before_reset", 32'(valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("reset_async_valid", 32'(valid), 32'd0);
    check("reset_async_busy", 32'(busy), 32'd0);
    m_busy  = '0;
    m_count = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_no_error", 32'(err), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_after_reset", 32'({serve, valid, err}), 32'd0);
    end
    check("count_after_reset", 32'(count), 32'(m_count));
    check("offers_left", 32'(exp_q.size()), 32'd0);
    check("errors_left", 32'(err_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
